// File: rtl/dp_pipe_ctrl.sv
// Valid/enable sequencer for the multi-precision FP multiply pipeline.
// Collapses bubbles, applies output backpressure and drains the pipe before any lane-mode change.
module dp_pipe_ctrl #(
  parameter int STAGES     = 4,
  parameter int SWITCH_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [1:0]                   in_mode,
  output logic                         in_ready,
  output logic [STAGES-1:0]            stage_en,
  output logic [STAGES-1:0]            stage_vld,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   cfg_mode,
  output logic [$clog2(STAGES+1)-1:0]  inflight,
  output logic                         busy,
  output logic                         err_illegal
);

  localparam int         IW           = $clog2(STAGES + 1);
  localparam int         CW           = $clog2(SWITCH_CYC + 1);
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STAGES-1:0] vld_q, vld_d, en;
  logic [1:0]        cfg_q, cfg_d, tgt_q, tgt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rdy, hole;
  logic [IW-1:0]     pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cfg_d   = cfg_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdy     = 1'b0;
    hole    = 1'b0;

    // A stage may load when any stage at or above it is empty, or the result leaves this cycle.
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole  = hole | ~vld_q[i];
      en[i] = hole | out_ready;
    end

    if (state_q == RUN) begin
      rdy   = en[0] & ((in_mode == cfg_q) | (in_mode == MODE_ILLEGAL));
      err_d = in_valid & en[0] & (in_mode == MODE_ILLEGAL);
      if (in_valid && (in_mode != MODE_ILLEGAL) && (in_mode != cfg_q)) begin
        state_d = DRAIN;
        tgt_d   = in_mode;
      end
    end

    vld_d = vld_q;
    for (int i = 1; i < STAGES; i++) begin
      if (en[i]) vld_d[i] = vld_q[i-1];
    end
    if (en[0]) vld_d[0] = in_valid & rdy & (in_mode != MODE_ILLEGAL);

    // Drain completes on the cycle whose retire leaves the pipe empty.
    case (state_q)
      RUN: ;
      DRAIN: begin
        if (vld_d == '0) begin
          state_d = SWITCH;
          cfg_d   = tgt_q;
          cnt_d   = CW'(SWITCH_CYC - 1);
        end
      end
      SWITCH: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < STAGES; i++) pop = pop + IW'(vld_q[i]);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q <= RUN;
      vld_q   <= '0;
      cfg_q   <= 2'd0;
      tgt_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      cfg_q   <= cfg_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = rdy;
  assign stage_en    = en;
  assign stage_vld   = vld_q;
  assign out_valid   = vld_q[STAGES-1];
  assign cfg_mode    = cfg_q;
  assign inflight    = pop;
  assign busy        = (state_q != RUN) | (pop != '0);
  assign err_illegal = err_q;

endmodule
